// File: rtl/dot_feeder.sv
// Byte-stream packer feeding a dot-product unit: loads a row and a column vector, issues them,
// then hands the returned sum downstream on valid/ready. Optional WAIT timeout via DOT_TIMEOUT_EN.
module dot_feeder #(
    parameter int N       = 32,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_axiiv,
    input  logic [W-1:0]        in_axiid,
    output logic                in_ready,
    output logic [N-1:0][W-1:0] row1,
    output logic [N-1:0][W-1:0] col2,
    output logic                axiov,
    input  logic                res_axiiv,
    input  logic [W-1:0]        res_axiid,
    output logic                out_axiov,
    output logic [W-1:0]        out_axiod,
    input  logic                out_ready,
    output logic                busy,
    output logic                err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (N < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("dot_feeder: N and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {LOAD_ROW, LOAD_COL, ISSUE, WAIT, SEND} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          take, last, timeout_hit;

    assign take = in_axiiv && in_ready;
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_ROW;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        axiov      = 1'b0;
        out_axiov  = 1'b0;
        busy       = 1'b1;
        case (state)
            LOAD_ROW: begin
                busy = 1'b0;
                if (take && last) state_next = LOAD_COL;
            end
            LOAD_COL: if (take && last) state_next = ISSUE;
            ISSUE: begin
                axiov      = 1'b1;
                state_next = WAIT;
            end
            // A result on the final permitted cycle beats the timeout.
            WAIT: begin
                if (res_axiiv)        state_next = SEND;
                else if (timeout_hit) state_next = LOAD_ROW;
            end
            SEND: begin
                out_axiov = 1'b1;
                if (out_ready) state_next = LOAD_ROW;
            end
            default: state_next = LOAD_ROW;
        endcase
    end

    // in_ready is registered from the next state so it drops right after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            in_ready  <= 1'b0;
            row1      <= '0;
            col2      <= '0;
            out_axiod <= '0;
        end else begin
            in_ready <= (state_next == LOAD_ROW) || (state_next == LOAD_COL);
            if (take) begin
                if (state == LOAD_ROW) row1[cnt] <= in_axiid;
                else                   col2[cnt] <= in_axiid;
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (state == WAIT && res_axiiv) out_axiod <= res_axiid;
        end
    end

`ifdef DOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          err_q;

    assign timeout_hit = (state == WAIT) && !res_axiiv && (wait_cnt == TW'(TIMEOUT - 1));
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_dot_feeder.sv
// Randomised bench for dot_feeder: behavioural dot unit, transaction-level model compared every
// cycle, result scoreboard and literal latency/value checks.
module tb_dot_feeder;

    localparam int N = 32, W = 8, TIMEOUT = 16, VW = N * W;

    logic                clk = 1'b0, rst = 1'b1;
    logic                in_axiiv = 1'b0;
    logic [W-1:0]        in_axiid = '0;
    logic                in_ready, axiov, res_axiiv, out_axiov, busy, err;
    logic [N-1:0][W-1:0] row1, col2;
    logic [W-1:0]        res_axiid, out_axiod;
    logic                out_ready = 1'b0;

    logic       dot_v = 1'b0, spur_v = 1'b0;
    logic [7:0] dot_d = '0, spur_d = '0;
    bit         dot_en = 1'b1, chk_en = 1'b0;
    int         or_mode = 0;

    assign res_axiiv = dot_v | spur_v;
    assign res_axiid = spur_v ? spur_d : dot_d;

    dot_feeder #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_axiiv(in_axiiv), .in_axiid(in_axiid), .in_ready(in_ready),
        .row1(row1), .col2(col2), .axiov(axiov), .res_axiiv(res_axiiv), .res_axiid(res_axiid),
        .out_axiov(out_axiov), .out_axiod(out_axiod), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: bytes taken so far, which phase the transaction is in.
    int         m_taken = 0, m_wcnt = 0;
    bit         m_rdy = 0, m_issue = 0, m_wait = 0, m_send = 0, m_err = 0;
    logic [7:0] m_res = '0;
    logic [7:0] m_row[N], m_col[N];

    initial begin
        foreach (m_row[k]) begin m_row[k] = '0; m_col[k] = '0; end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_taken = 0; m_rdy = 0; m_issue = 0; m_wait = 0; m_send = 0;
                m_err = 0; m_res = '0; m_wcnt = 0;
                foreach (m_row[k]) begin m_row[k] = '0; m_col[k] = '0; end
            end else begin
                if (m_issue) begin
                    m_issue = 0; m_wait = 1; m_wcnt = 0;
                end else if (m_wait) begin
                    if (res_axiiv) begin
                        m_res = res_axiid; m_wait = 0; m_send = 1;
                    end else begin
                        m_wcnt++;
`ifdef DOT_TIMEOUT_EN
                        if (m_wcnt == TIMEOUT) begin m_err = 1; m_wait = 0; end
`endif
                    end
                end else if (m_send) begin
                    if (out_ready) m_send = 0;
                end else if (in_axiiv && m_rdy) begin
                    if (m_taken < N) m_row[m_taken] = in_axiid;
                    else             m_col[m_taken - N] = in_axiid;
                    m_taken++;
                    if (m_taken == 2 * N) begin m_taken = 0; m_issue = 1; end
                end
                m_rdy = !(m_issue || m_wait || m_send);
            end
        end
    end

    function automatic logic [VW-1:0] pack(input logic [7:0] a[N]);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = a[k];
        return v;
    endfunction

    // Behavioural dot unit: result 3 cycles after the issue pulse, 8-bit wrapping sum.
    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (axiov && dot_en && !rst) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'(row1[k]) * int'(col2[k]);
                repeat (3) @(posedge clk);
                #1 dot_v = 1'b1; dot_d = s[7:0];
                @(posedge clk);
                #1 dot_v = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Per-cycle compare and result scoreboard.
    logic [7:0] exp_q[$];
    logic [7:0] last_out = '0;
    int         n_res = 0, t_axiov = -1, t_outv = -1;
    bit         prev_ov = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready", in_ready, m_rdy);
            chk("axiov", axiov, m_issue);
            chk("out_axiov", out_axiov, m_send);
            chk("out_axiod", out_axiod, m_res);
            chk("busy", busy, m_issue || m_wait || m_send || (m_taken >= N));
            chk("err", err, m_err);
            chk("row1", row1, pack(m_row));
            chk("col2", col2, pack(m_col));
            if (axiov) t_axiov = cyc;
            if (out_axiov && !prev_ov) t_outv = cyc;
            prev_ov = out_axiov;
            if (out_axiov && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1'b1, 1'b0);
                else                   chk("result", out_axiod, exp_q.pop_front());
                last_out = out_axiod;
                n_res++;
            end
        end
    end

    logic [7:0] vr[N], vc[N];
    int         t_acc = 0;

    task automatic push(input logic [7:0] b);
        int g = 0;
        bit ok = 0;
        in_axiiv = 1'b1; in_axiid = b;
        while (!ok && g < 300) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) t_acc = cyc;
            @(posedge clk);
            #1 g++;
        end
        if (!ok) chk("push_timeout", 1'b0, 1'b1);
        in_axiiv = 1'b0; in_axiid = 8'($urandom);
    endtask

    task automatic send_vec(input int gap_max, input bit spur);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(vr[k]) * int'(vc[k]);
        if (dot_en) exp_q.push_back(s[7:0]);
        for (int i = 0; i < 2 * N; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_axiid = 8'($urandom);
                @(posedge clk);
                #1;
            end
            if (spur && i == N + 5) begin
                spur_v = 1'b1; spur_d = 8'hAA;
                @(posedge clk);
                #1 spur_v = 1'b0;
            end
            push(i < N ? vr[i] : vc[i - N]);
        end
    endtask

    task automatic wait_result();
        int n0 = n_res, g = 0;
        while (n_res == n0 && g < 300) begin
            @(negedge clk);
            #1 g++;
        end
        chk("result_arrived", n_res > n0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_axiov", axiov | out_axiov | busy | err, 1'b0);
        chk("rst_row1", row1, '0);
        chk("rst_out_axiod", out_axiod, '0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: all-ones row by all-twos column, plus latency.
        or_mode = 0;
        foreach (vr[k]) begin vr[k] = 8'h01; vc[k] = 8'h02; end
        send_vec(0, 0);
        wait_result();
        chk("t1_value", last_out, 8'h40);
        chk("t1_axiov_lat", t_axiov - t_acc, 1);
        chk("t1_outv_lat", t_outv - t_acc, 5);
        @(negedge clk);
        chk("t1_outv_one_cycle", out_axiov, 1'b0);
        @(posedge clk);
        #1;

        // Test 2: ramp times ones.
        foreach (vr[k]) begin vr[k] = 8'(k); vc[k] = 8'h01; end
        send_vec(1, 0);
        wait_result();
        chk("t2_value", last_out, 8'hF0);

        // Test 3: back-pressure held for 10 cycles while bytes are offered.
        or_mode = 2;
        foreach (vr[k]) begin vr[k] = 8'($urandom); vc[k] = 8'($urandom); end
        send_vec(0, 0);
        for (int g = 0; g < 300 && !out_axiov; g++) @(negedge clk);
        chk("t3_in_send", out_axiov, 1'b1);
        held = out_axiod;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            in_axiiv = ~in_axiiv; in_axiid = 8'($urandom);
            @(negedge clk);
            chk("t3_hold_valid", out_axiov, 1'b1);
            chk("t3_hold_data", out_axiod, held);
            chk("t3_no_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_axiiv = 1'b0;
        or_mode = 0;
        wait_result();

        // Test 4: stray result during column load is ignored.
        foreach (vr[k]) begin vr[k] = 8'($urandom); vc[k] = 8'($urandom); end
        send_vec(0, 1);
        wait_result();

        // Random vectors, random gaps and random back-pressure.
        or_mode = 1;
        for (int r = 0; r < 4; r++) begin
            foreach (vr[k]) begin vr[k] = 8'($urandom); vc[k] = 8'($urandom); end
            send_vec(2, 0);
            wait_result();
        end
        or_mode = 0;

        // Test 5: reset after 20 row bytes, then a fresh full vector.
        for (int i = 0; i < 20; i++) push(8'($urandom_range(1, 255)));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", in_ready, 1'b0);
        chk("t5_ctl", axiov | out_axiov | busy | err, 1'b0);
        chk("t5_row1", row1, '0);
        chk("t5_col2", col2, '0);
        chk("t5_out_axiod", out_axiod, '0);
        @(posedge clk);
        #1;
        foreach (vr[k]) begin vr[k] = 8'($urandom); vc[k] = 8'($urandom); end
        send_vec(1, 0);
        wait_result();

`ifdef DOT_TIMEOUT_EN
        // Test 6: silent dot unit trips the timeout.
        dot_en = 1'b0;
        send_vec(0, 0);
        while (cyc < t_acc + 17) @(negedge clk);
        chk("t6_err_before", err, 1'b0);
        @(negedge clk);
        chk("t6_err", err, 1'b1);
        chk("t6_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 dot_en = 1'b1;
`endif

        repeat (5) @(posedge clk);
        chk("results_drained", 32'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
